// File: rtl/uart_tx_frame_serializer.sv
// UART transmit serializer: start, DATA_WIDTH data bits, optional parity, 1-2 stop bits.
// Define UART_TX_PARITY_EN to build in the PARITY state and the par_typ handling.
module uart_tx_frame_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MSB_FIRST  = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  tick,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] shreg, sh_next, shifted;
  logic [CW-1:0]         cnt, cnt_next;
  logic                  stop_cnt, stop_next;
  logic                  first_bit;
  logic                  tx_next, busy_next, done_next;

`ifdef UART_TX_PARITY_EN
  logic par_bit, par_next;
`else
  logic unused_par_typ;
  assign unused_par_typ = par_typ;
`endif

  // The bit about to go on the line always sits at the outgoing end of shreg.
  assign first_bit = (MSB_FIRST != 0) ? shreg[DATA_WIDTH-1] : shreg[0];
  assign shifted   = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
      tx_out   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      shreg    <= sh_next;
      cnt      <= cnt_next;
      stop_cnt <= stop_next;
`ifdef UART_TX_PARITY_EN
      par_bit  <= par_next;
`endif
      tx_out   <= tx_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    sh_next    = shreg;
    cnt_next   = cnt;
    stop_next  = stop_cnt;
`ifdef UART_TX_PARITY_EN
    par_next   = par_bit;
`endif
    case (state)
      IDLE: begin
        if (data_valid) begin
          state_next = ARMED;
          sh_next    = p_data;
          cnt_next   = '0;
          stop_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_next   = (^p_data) ^ par_typ;
`endif
        end
      end
      ARMED: if (tick) state_next = START;
      START: begin
        if (tick) begin
          state_next = DATA;
          sh_next    = shifted;
          cnt_next   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt == CNT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
            stop_next  = 1'b0;
          end else begin
            cnt_next = cnt + 1'b1;
            sh_next  = shifted;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_next = STOP;
`endif
      STOP: begin
        if (tick) begin
          if (stop_cnt == STOP_LAST) state_next = IDLE;
          else stop_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_next   = tx_out;
    done_next = 1'b0;
    busy_next = (state_next != IDLE);
    case (state)
      ARMED: if (tick) tx_next = 1'b0;
      START: if (tick) tx_next = first_bit;
      DATA: begin
        if (tick) begin
          if (cnt == CNT_LAST) begin
`ifdef UART_TX_PARITY_EN
            tx_next = par_bit;
`else
            tx_next = 1'b1;
`endif
          end else begin
            tx_next = first_bit;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) tx_next = 1'b1;
`endif
      STOP: begin
        if (tick && (stop_cnt == STOP_LAST)) begin
          tx_next   = 1'b1;
          done_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Bench for uart_tx_frame_serializer: dut0 is LSB-first/1 stop, dut1 is MSB-first/2 stop.
module tb_uart_tx_frame_serializer;

  logic       CLK = 1'b0;
  logic [1:0] rst, tk, dv, ptv, tx, busy, done;
  logic [7:0] pd [2];
  int         n_tests = 0;
  int         n_fail  = 0;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  always #5 CLK = ~CLK;

  uart_tx_frame_serializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .STOP_BITS(1)) dut0 (
    .CLK(CLK), .RST(rst[0]), .tick(tk[0]), .p_data(pd[0]), .data_valid(dv[0]),
    .par_typ(ptv[0]), .tx_out(tx[0]), .busy(busy[0]), .done(done[0]));

  uart_tx_frame_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1), .STOP_BITS(2)) dut1 (
    .CLK(CLK), .RST(rst[1]), .tick(tk[1]), .p_data(pd[1]), .data_valid(dv[1]),
    .par_typ(ptv[1]), .tx_out(tx[1]), .busy(busy[1]), .done(done[1]));

  function automatic int stops(int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int flen(int d);
    return 1 + 8 + PAR + stops(d);
  endfunction

  // Line level during bit period k of a frame, counted from the start bit.
  function automatic logic model_bit(int d, logic [7:0] data, logic pt, int k);
    int idx;
    if (k == 0) return 1'b0;
    if (k <= 8) begin
      idx = (d == 1) ? (8 - k) : (k - 1);
      return data[idx];
    end
    if (PAR == 1 && k == 9) return (^data) ^ pt;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_accept(int d, logic [7:0] data, logic pt, logic with_tick);
    dv[d] = 1'b1; pd[d] = data; ptv[d] = pt; tk[d] = with_tick;
    step();
    dv[d] = 1'b0; tk[d] = 1'b0; pd[d] = 8'($urandom); ptv[d] = 1'($urandom);
    n_tests++;
    if (busy[d] !== 1'b1 || tx[d] !== 1'b1 || done[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL accept dut%0d: busy/tx/done got %b%b%b, expected 110", d, busy[d], tx[d], done[d]);
    end
  endtask

  task automatic play_frame(int d, logic [7:0] data, logic pt, int gap, int intr_at, int abort_at);
    logic prev;
    logic e;
    int   len;
    prev = 1'b1;
    len  = flen(d);
    for (int k = 0; k <= len; k++) begin
      for (int g = 1; g < gap; g++) begin
        step();
        n_tests++;
        if (tx[d] !== prev || busy[d] !== 1'b1) begin
          n_fail++;
          $display("FAIL gap_hold dut%0d k=%0d: tx/busy got %b%b, expected %b1", d, k, tx[d], busy[d], prev);
        end
      end
      tk[d] = 1'b1;
      step();
      tk[d] = 1'b0;
      if (k == intr_at) begin dv[d] = 1'b1; pd[d] = 8'h3C; end
      n_tests++;
      if (k < len) begin
        e = model_bit(d, data, pt, k);
        if (tx[d] !== e || busy[d] !== 1'b1 || done[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL tx_bit dut%0d data=%h k=%0d: tx/busy/done got %b%b%b, expected %b10",
                   d, data, k, tx[d], busy[d], done[d], e);
        end
        prev = e;
      end else if (tx[d] !== 1'b1 || busy[d] !== 1'b0 || done[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL frame_end dut%0d data=%h: tx/busy/done got %b%b%b, expected 101",
                 d, data, tx[d], busy[d], done[d]);
      end
      if (k == abort_at) return;
    end
    step();
    n_tests++;
    if (done[d] !== 1'b0 || busy[d] !== dv[d] || tx[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL after_done dut%0d: tx/busy/done got %b%b%b, expected 1%b0", d, tx[d], busy[d], done[d], dv[d]);
    end
  endtask

  task automatic test_reset();
    rst = 2'b11; tk = '0; dv = '0; ptv = '0; pd[0] = '0; pd[1] = '0;
    step(); step();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (tx[d] !== 1'b1 || busy[d] !== 1'b0 || done[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset dut%0d: tx/busy/done got %b%b%b, expected 100", d, tx[d], busy[d], done[d]);
      end
    end
    // Reset must win over simultaneous acceptance and tick.
    dv = 2'b11; tk = 2'b11;
    step();
    dv = '0; tk = '0;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (tx[d] !== 1'b1 || busy[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_priority dut%0d: tx/busy got %b%b, expected 10", d, tx[d], busy[d]);
      end
    end
    rst = '0;
    step();
  endtask

  task automatic test_idle_tick();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) begin
        tk[d] = 1'b1; step(); tk[d] = 1'b0; step();
        n_tests++;
        if (tx[d] !== 1'b1 || busy[d] !== 1'b0 || done[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_tick dut%0d: tx/busy/done got %b%b%b, expected 100", d, tx[d], busy[d], done[d]);
        end
      end
    end
  endtask

  task automatic test_known_vectors();
    do_accept(0, 8'hA5, 1'b0, 1'b0); play_frame(0, 8'hA5, 1'b0, 16, -1, -1);
    do_accept(0, 8'h07, 1'b0, 1'b0); play_frame(0, 8'h07, 1'b0, 4, -1, -1);
    do_accept(0, 8'h07, 1'b1, 1'b0); play_frame(0, 8'h07, 1'b1, 4, -1, -1);
    do_accept(1, 8'h80, 1'b0, 1'b0); play_frame(1, 8'h80, 1'b0, 5, -1, -1);
    do_accept(1, 8'h07, 1'b1, 1'b0); play_frame(1, 8'h07, 1'b1, 3, -1, -1);
  endtask

  task automatic test_back_to_back();
    logic pt2;
    for (int d = 0; d < 2; d++) begin
      do_accept(d, 8'hA5, 1'b0, 1'b0);
      play_frame(d, 8'hA5, 1'b0, 4, 3, -1);
      pt2 = ptv[d];
      dv[d] = 1'b0;
      play_frame(d, 8'h3C, pt2, 3, -1, -1);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] data;
    for (int d = 0; d < 2; d++) begin
      do_accept(d, 8'h5A, 1'b1, 1'b0);
      play_frame(d, 8'h5A, 1'b1, 3, -1, 3);
      rst[d] = 1'b1; step(); rst[d] = 1'b0;
      n_tests++;
      if (tx[d] !== 1'b1 || busy[d] !== 1'b0 || done[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid dut%0d: tx/busy/done got %b%b%b, expected 100", d, tx[d], busy[d], done[d]);
      end
      data = 8'($urandom);
      do_accept(d, data, 1'b0, 1'b0);
      play_frame(d, data, 1'b0, 3, -1, -1);
    end
  endtask

  task automatic test_same_cycle_tick();
    logic [7:0] data;
    logic       pt;
    for (int d = 0; d < 2; d++) begin
      data = 8'($urandom); pt = 1'($urandom);
      do_accept(d, data, pt, 1'b1);
      play_frame(d, data, pt, 3, -1, -1);
    end
  endtask

  task automatic test_random();
    logic [7:0] data;
    logic       pt;
    int         gap;
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < 2; d++) begin
        data = 8'($urandom); pt = 1'($urandom); gap = int'($urandom_range(2, 6));
        do_accept(d, data, pt, 1'b0);
        play_frame(d, data, pt, gap, -1, -1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_tick();
    test_known_vectors();
    test_back_to_back();
    test_reset_midframe();
    test_same_cycle_tick();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
